// File: rtl/fall_pkg.sv
// fall_pkg: shared state encoding and widths for the fall classifier.
package fall_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FREEFALL    = 3'd1,
    IMPACT_WAIT = 3'd2,
    SETTLE      = 3'd3,
    STILL       = 3'd4,
    ALARM       = 3'd5
  } fall_state_t;

  localparam int FALL_CNT_W = 16;

endpackage

// File: rtl/fall_mag_sq.sv
// fall_mag_sq: two-stage squared-magnitude pipeline for a signed 3-axis sample.
// Stage 1 registers the three squares, stage 2 registers their sum with mag_valid.
module fall_mag_sq #(
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   ax,
  input  logic signed [DATA_W-1:0]   ay,
  input  logic signed [DATA_W-1:0]   az,
  output logic [2*DATA_W-1:0]        mag_sq,
  output logic                       mag_valid
);

  localparam int MAG_W = 2 * DATA_W;

  logic signed [MAG_W-1:0] ax_ext, ay_ext, az_ext;
  logic signed [MAG_W-1:0] prod_x, prod_y, prod_z;
  logic [MAG_W-1:0]        sq_x_p1_d, sq_x_p1_q;
  logic [MAG_W-1:0]        sq_y_p1_d, sq_y_p1_q;
  logic [MAG_W-1:0]        sq_z_p1_d, sq_z_p1_q;
  logic                    vld_p1_d, vld_p1_q;
  logic [MAG_W-1:0]        mag_p2_d, mag_p2_q;
  logic                    vld_p2_d, vld_p2_q;

  // Squares are non-negative and fit in MAG_W, so they are kept unsigned from here on
  always_comb begin
    ax_ext    = MAG_W'(ax);
    ay_ext    = MAG_W'(ay);
    az_ext    = MAG_W'(az);
    prod_x    = ax_ext * ax_ext;
    prod_y    = ay_ext * ay_ext;
    prod_z    = az_ext * az_ext;
    // stage 1: squares
    sq_x_p1_d = in_valid ? $unsigned(prod_x) : sq_x_p1_q;
    sq_y_p1_d = in_valid ? $unsigned(prod_y) : sq_y_p1_q;
    sq_z_p1_d = in_valid ? $unsigned(prod_z) : sq_z_p1_q;
    vld_p1_d  = in_valid;
    // stage 2: sum of squares (three full-scale squares stay below 2^MAG_W)
    mag_p2_d  = vld_p1_q ? (sq_x_p1_q + sq_y_p1_q + sq_z_p1_q) : mag_p2_q;
    vld_p2_d  = vld_p1_q;
  end

  // Pipeline registers; reset drops any in-flight sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_x_p1_q <= '0;
      sq_y_p1_q <= '0;
      sq_z_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      mag_p2_q  <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      sq_x_p1_q <= sq_x_p1_d;
      sq_y_p1_q <= sq_y_p1_d;
      sq_z_p1_q <= sq_z_p1_d;
      vld_p1_q  <= vld_p1_d;
      mag_p2_q  <= mag_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign mag_sq    = mag_p2_q;
  assign mag_valid = vld_p2_q;

endmodule

// File: rtl/fall_classifier.sv
// fall_classifier: recognises free-fall -> impact -> settle -> stillness on the
// squared magnitude of a 3-axis stream and latches an alarm until acknowledged.
// Build option FALL_CLASSIFIER_FREEFALL_EN: when defined the free-fall and
// impact-window phases are included; when undefined an impact seen from IDLE
// starts the settle phase directly.
module fall_classifier
  import fall_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int FF_MIN_SAMPLES = 5,
  parameter int IMPACT_WIN     = 50,
  parameter int SETTLE_SAMPLES = 20,
  parameter int STILL_SAMPLES  = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] ax,
  input  logic signed [DATA_W-1:0] ay,
  input  logic signed [DATA_W-1:0] az,
  input  logic [2*DATA_W-1:0]      ff_thresh_sq,
  input  logic [2*DATA_W-1:0]      impact_thresh_sq,
  input  logic [2*DATA_W-1:0]      still_lo_sq,
  input  logic [2*DATA_W-1:0]      still_hi_sq,
  input  logic                     alarm_ack,
  output logic                     fall_pulse,
  output logic                     fall_alarm,
  output logic [15:0]              fall_count,
  output logic [2:0]               state_o
);

  localparam int MAG_W   = 2 * DATA_W;
  localparam int WIN_A   = (FF_MIN_SAMPLES > IMPACT_WIN) ? FF_MIN_SAMPLES : IMPACT_WIN;
  localparam int WIN_B   = (SETTLE_SAMPLES > STILL_SAMPLES) ? SETTLE_SAMPLES : STILL_SAMPLES;
  localparam int WIN_MAX = (WIN_A > WIN_B) ? WIN_A : WIN_B;
  localparam int CNT_W   = $clog2(WIN_MAX) + 1;

  logic [MAG_W-1:0]      mag_sq;
  logic                  mag_valid;
  fall_state_t           state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  pulse_d, pulse_q;
  logic [FALL_CNT_W-1:0] fall_count_d, fall_count_q;
  logic                  is_impact, in_band;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [FALL_CNT_W-1:0] sat_inc_falls(input logic [FALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fall_mag_sq #(.DATA_W(DATA_W)) u_mag (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ax        (ax),
    .ay        (ay),
    .az        (az),
    .mag_sq    (mag_sq),
    .mag_valid (mag_valid)
  );

  assign is_impact = (mag_sq > impact_thresh_sq);
  assign in_band   = (mag_sq >= still_lo_sq) && (mag_sq <= still_hi_sq);

`ifdef FALL_CLASSIFIER_FREEFALL_EN
  logic is_ff, ff_long_enough;
  assign is_ff          = (mag_sq < ff_thresh_sq);
  assign ff_long_enough = (cnt_q >= CNT_W'(FF_MIN_SAMPLES - 1));
`else
  logic unused_ff_thresh;
  assign unused_ff_thresh = ^ff_thresh_sq;
`endif

  // State, sample counter, pulse and fall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
      fall_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
      fall_count_q <= fall_count_d;
    end
  end

  // Next-state logic; everything but the ALARM exit waits for a magnitude
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef FALL_CLASSIFIER_FREEFALL_EN
        if (mag_valid && is_ff) state_d = FREEFALL;
`else
        if (mag_valid && is_impact) state_d = SETTLE;
`endif
      end
`ifdef FALL_CLASSIFIER_FREEFALL_EN
      FREEFALL: begin
        if (mag_valid && !is_ff) begin
          if (!ff_long_enough) state_d = IDLE;
          else if (is_impact)  state_d = SETTLE;
          else                 state_d = IMPACT_WAIT;
        end
      end
      IMPACT_WAIT: begin
        if (mag_valid) begin
          if (is_impact)                              state_d = SETTLE;
          else if (cnt_q == CNT_W'(IMPACT_WIN - 1))   state_d = IDLE;
        end
      end
`endif
      SETTLE: begin
        if (mag_valid && cnt_q == CNT_W'(SETTLE_SAMPLES - 1)) state_d = STILL;
      end
      STILL: begin
        if (mag_valid) begin
          if (!in_band)                                  state_d = IDLE;
          else if (cnt_q == CNT_W'(STILL_SAMPLES - 1))   state_d = ALARM;
        end
      end
      ALARM: begin
        if (alarm_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared counter restarts on any state change; alarm entry bumps the fall count
  always_comb begin
    cnt_d        = cnt_q;
    pulse_d      = (state_d == ALARM) && (state_q != ALARM);
    fall_count_d = pulse_d ? sat_inc_falls(fall_count_q) : fall_count_q;
    if (state_d != state_q) cnt_d = '0;
    else if (mag_valid)     cnt_d = sat_inc_cnt(cnt_q);
  end

  // Outputs decoded from registered state
  always_comb begin
    fall_alarm = (state_q == ALARM);
    fall_pulse = pulse_q;
    fall_count = fall_count_q;
    state_o    = state_q;
  end

endmodule

// File: tb/tb_fall_classifier.sv
// tb_fall_classifier: directed checks of the fall classifier in either build
// (FALL_CLASSIFIER_FREEFALL_EN defined or not).
module tb_fall_classifier;

`ifdef FALL_CLASSIFIER_FREEFALL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  localparam logic [31:0] S_IDLE = 0, S_FF = 1, S_IW = 2, S_SETTLE = 3, S_STILL = 4, S_ALARM = 5;

  logic               clk, rst, in_valid, alarm_ack;
  logic signed [15:0] ax, ay, az;
  logic [31:0]        ff_thresh_sq, impact_thresh_sq, still_lo_sq, still_hi_sq;
  logic               fall_pulse, fall_alarm;
  logic [15:0]        fall_count;
  logic [2:0]         state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  fall_classifier #(
    .DATA_W(16), .FF_MIN_SAMPLES(5), .IMPACT_WIN(50),
    .SETTLE_SAMPLES(20), .STILL_SAMPLES(200)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .ax(ax), .ay(ay), .az(az),
    .ff_thresh_sq(ff_thresh_sq), .impact_thresh_sq(impact_thresh_sq),
    .still_lo_sq(still_lo_sq), .still_hi_sq(still_hi_sq),
    .alarm_ack(alarm_ack),
    .fall_pulse(fall_pulse), .fall_alarm(fall_alarm),
    .fall_count(fall_count), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (fall_pulse === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y, input int z);
    @(negedge clk);
    in_valid = 1'b1;
    ax = 16'(x); ay = 16'(y); az = 16'(z);
  endtask

  task automatic send_n(input int n, input int z);
    for (int i = 0; i < n; i++) send(0, 0, z);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // 6 free-fall samples then one impact: lands in SETTLE in either build
  task automatic to_settle();
    send_n(6, 500);
    send(32000, 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alarm_ack = 1'b0;
    ax = '0; ay = '0; az = '0;
    ff_thresh_sq     = 32'd1000000;    // 1000^2
    impact_thresh_sq = 32'd900000000;  // 30000^2
    still_lo_sq      = 32'd196000000;  // 14000^2
    still_hi_sq      = 32'd324000000;  // 18000^2
    repeat (2) @(negedge clk);
    check("reset_state", state_o, S_IDLE);
    check("reset_alarm", fall_alarm, 0);
    check("reset_pulse", fall_pulse, 0);
    check("reset_count", fall_count, 0);
    rst = 1'b0;

    // magnitude exactly at the impact bound is not an impact
    send(0, 0, 30000); idle(3);
    check("impact_eq_thresh", state_o, S_IDLE);

    // full fall
    send_n(6, 500); idle(3);
    check("ff_entry", state_o, FF_EN ? S_FF : S_IDLE);
    send(32000, 0, 0); idle(3);
    check("impact_to_settle", state_o, S_SETTLE);
    send_n(20, 20000); idle(3);
    check("settle_to_still", state_o, S_STILL);
    send_n(200, 16384); idle(2);
    check("pulse_not_early", fall_pulse, 0);
    check("still_before_alarm", state_o, S_STILL);
    idle(1);
    check("pulse_at_3clk", fall_pulse, 1);
    check("alarm_state", state_o, S_ALARM);
    check("alarm_high", fall_alarm, 1);
    check("count_one", fall_count, 1);
    idle(1);
    check("pulse_one_cycle", fall_pulse, 0);
    check("alarm_latched", fall_alarm, 1);
    check("single_pulse", pulses, 1);

    // samples ignored while in ALARM
    send(0, 0, 500); send(0, 0, 25000); idle(3);
    check("alarm_ignores_samples", state_o, S_ALARM);

    // acknowledge
    @(negedge clk); alarm_ack = 1'b1;
    @(negedge clk); alarm_ack = 1'b0;
    check("ack_state", state_o, S_IDLE);
    check("ack_alarm", fall_alarm, 0);
    check("ack_count_kept", fall_count, 1);

    // movement at STILL sample 150; ack held during settle is ignored
    to_settle();
    alarm_ack = 1'b1;
    send_n(20, 20000); idle(3);
    alarm_ack = 1'b0;
    check("ack_ignored_outside_alarm", state_o, S_STILL);
    send(0, 0, 14000); send(0, 0, 18000); idle(3);
    check("band_inclusive", state_o, S_STILL);
    send_n(147, 16384); send(0, 0, 25000); idle(2);
    check("move_latency", state_o, S_STILL);
    idle(1);
    check("move_to_idle", state_o, S_IDLE);
    check("move_no_alarm", fall_alarm, 0);

    // just above the stillness band
    to_settle(); send_n(20, 20000); send(0, 0, 18001); idle(3);
    check("above_band_idle", state_o, S_IDLE);
    check("no_extra_pulse", pulses, 1);

    // second fall, ack arriving on the alarm entry cycle
    to_settle(); send_n(20, 20000); send_n(200, 16384);
    idle(1);
    @(negedge clk); in_valid = 1'b0; alarm_ack = 1'b1;
    check("second_pre_alarm", state_o, S_STILL);
    @(negedge clk);
    check("second_alarm_entry", state_o, S_ALARM);
    check("second_pulse", fall_pulse, 1);
    check("count_two", fall_count, 2);
    @(negedge clk); alarm_ack = 1'b0;
    check("ack_on_entry_exit", state_o, S_IDLE);
    check("two_pulses", pulses, 2);

`ifdef FALL_CLASSIFIER_FREEFALL_EN
    // too short a free-fall before impact
    send_n(3, 500); send(32000, 0, 0); idle(3);
    check("short_ff_idle", state_o, S_IDLE);
    // impact window: the first non-free-fall sample enters IMPACT_WAIT,
    // the window then runs for 50 more samples
    send_n(6, 500); send_n(50, 16384); idle(3);
    check("window_open", state_o, S_IW);
    send(0, 0, 16384); idle(3);
    check("window_expired", state_o, S_IDLE);
    check("no_pulse_ff_cases", pulses, 2);
    to_settle(); send_n(20, 20000); send_n(10, 16384); idle(3);
`else
    // without the free-fall phase, an impact from IDLE alone starts the sequence
    send_n(3, 500); send(32000, 0, 0); idle(3);
    check("direct_impact_settle", state_o, S_SETTLE);
    send_n(20, 20000); send_n(10, 16384); idle(3);
`endif
    check("mid_still", state_o, S_STILL);

    // asynchronous reset mid-STILL with a sample in flight
    send(0, 0, 16384);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_state", state_o, S_IDLE);
    check("rst_alarm", fall_alarm, 0);
    check("rst_pulse", fall_pulse, 0);
    check("rst_count", fall_count, 0);
    @(negedge clk); rst = 1'b0;
    idle(3);
    check("rst_drops_inflight", state_o, S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
